// File: rtl/pipe_hazard_ctl_if.sv
// Hazard-controller bus: ID-stage operand/destination info, EX resolution,
// WB write-back info going in; PC/latch enables and scoreboard view coming out.
// master = pipeline datapath side, slave = pipe_hazard_ctl.
interface pipe_hazard_ctl_if #(
    parameter int REGNOBITS = 4,
    parameter int REGWORDS  = 16
);
    logic                 id_valid;
    logic [REGNOBITS-1:0] id_rs;
    logic [REGNOBITS-1:0] id_rt;
    logic                 id_rs_used;
    logic                 id_rt_used;
    logic                 id_wr_reg;
    logic [REGNOBITS-1:0] id_wregno;
    logic                 id_is_ctl;
    logic                 ex_resolve;
    logic                 ex_mispred;
    logic                 wb_wr_reg;
    logic [REGNOBITS-1:0] wb_wregno;
    logic                 stall_pipe;
    logic                 bubble_id;
    logic                 flush;
    logic                 issue;
    logic [REGWORDS-1:0]  pend_busy;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_wr_reg,
               id_wregno, id_is_ctl, ex_resolve, ex_mispred, wb_wr_reg, wb_wregno,
        input  stall_pipe, bubble_id, flush, issue, pend_busy
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_wr_reg,
               id_wregno, id_is_ctl, ex_resolve, ex_mispred, wb_wr_reg, wb_wregno,
        output stall_pipe, bubble_id, flush, issue, pend_busy
    );
endinterface

// File: rtl/pipe_hazard_ctl.sv
// pipe_hazard_ctl: pending-write scoreboard, RAW/WAW hazard detection and
// branch/JAL sequencing for the FE/ID/EX/MEM/WB pipeline.
// Optional feature macro HAZ_WB_BYPASS_EN: when defined, a read of a register
// whose single pending write is being written back this cycle is not a hazard
// (the register file writes on the negative edge).
module pipe_hazard_ctl #(
    parameter int REGNOBITS = 4,
    parameter int REGWORDS  = 16,
    parameter int PENDBITS  = 2
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_CTL_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    localparam logic [PENDBITS-1:0] PEND_MAX = '1;
    localparam logic [PENDBITS-1:0] PEND_ONE = PENDBITS'(1);

    state_t              state_q;
    logic [PENDBITS-1:0] pend_q [REGWORDS];
    logic [PENDBITS-1:0] pend_d [REGWORDS];

    logic rs_hit, rt_hit, rs_byp, rt_byp;
    logic raw_hz, waw_hz, hz;
    logic stall_int, bubble_int, flush_int, issue_int;

    // Hazard detection against the scoreboard, same-cycle from ID inputs.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        rs_hit = bus.id_rs_used && (pend_q[bus.id_rs] != '0);
        rt_hit = bus.id_rt_used && (pend_q[bus.id_rt] != '0);
`ifdef HAZ_WB_BYPASS_EN
        rs_byp = (pend_q[bus.id_rs] == PEND_ONE) && bus.wb_wr_reg && (bus.wb_wregno == bus.id_rs);
        rt_byp = (pend_q[bus.id_rt] == PEND_ONE) && bus.wb_wr_reg && (bus.wb_wregno == bus.id_rt);
`else
        rs_byp = 1'b0;
        rt_byp = 1'b0;
`endif
        raw_hz = bus.id_valid && ((rs_hit && !rs_byp) || (rt_hit && !rt_byp));
        waw_hz = bus.id_valid && bus.id_wr_reg && (pend_q[bus.id_wregno] == PEND_MAX);
        hz     = raw_hz || waw_hz;
    end

    // Pipeline control outputs decoded from state and hazards; forced low in reset.
    always_comb begin
        stall_int  = ((state_q == ST_RUN) && hz) || (state_q == ST_CTL_WAIT);
        bubble_int = stall_int || (state_q == ST_FLUSH);
        flush_int  = (state_q == ST_FLUSH);
        issue_int  = (state_q == ST_RUN) && bus.id_valid && !hz;

        bus.stall_pipe = !reset && stall_int;
        bus.bubble_id  = !reset && bubble_int;
        bus.flush      = !reset && flush_int;
        bus.issue      = !reset && issue_int;
        for (int i = 0; i < REGWORDS; i++) begin
            bus.pend_busy[i] = !reset && (pend_q[i] != '0);
        end
    end

    // Scoreboard next state: +1 on issue of a writer, -1 on write-back,
    // unchanged when both hit the same register; saturates, never wraps.
    always_comb begin
        for (int i = 0; i < REGWORDS; i++) begin
            logic inc, dec;
            inc = issue_int && bus.id_wr_reg && (bus.id_wregno == REGNOBITS'(i));
            dec = bus.wb_wr_reg && (bus.wb_wregno == REGNOBITS'(i));
            pend_d[i] = pend_q[i];
            if (inc && !dec && (pend_q[i] != PEND_MAX)) begin
                pend_d[i] = pend_q[i] + PEND_ONE;
            end else if (dec && !inc && (pend_q[i] != '0)) begin
                pend_d[i] = pend_q[i] - PEND_ONE;
            end
        end
    end

    // Scoreboard registers.
    always_ff @(posedge clk) begin
        // NOTE: the counters are a small flop array, not RAM, so clearing them in reset is cheap and required.
        for (int i = 0; i < REGWORDS; i++) begin
            if (reset) begin
                pend_q[i] <= '0;
            end else begin
                // NOTE: sequential state uses non-blocking assignment so all flops sample pre-edge values.
                pend_q[i] <= pend_d[i];
            end
        end
    end

    // Control sequencing: hold the front end from a branch/JAL issue until EX
    // resolves it, then squash one cycle on a misprediction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (issue_int && bus.id_is_ctl) state_q <= ST_CTL_WAIT;
                end
                ST_CTL_WAIT: begin
                    if (bus.ex_resolve) state_q <= bus.ex_mispred ? ST_FLUSH : ST_RUN;
                end
                ST_FLUSH: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    // A write-back to a register with nothing pending means the pipeline and
    // the scoreboard have lost track of each other.
    a_no_dec_at_zero: assert property (
        @(posedge clk) disable iff (reset)
        !(bus.wb_wr_reg && (pend_q[bus.wb_wregno] == '0))
    );

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Self-checking bench for pipe_hazard_ctl: a directed vector table, hand
// sequences for the multi-cycle corner cases, and a randomized run against an
// in-flight-write queue model of the pipeline.
module tb_pipe_hazard_ctl;

`ifdef HAZ_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_hazard_ctl_if bus ();

    pipe_hazard_ctl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       v;
        logic [3:0] rs;
        logic       rsu;
        logic [3:0] rt;
        logic       rtu;
        logic       wr;
        logic [3:0] wn;
        logic       ctl;
        logic       res;
        logic       mis;
        logic       wbw;
        logic [3:0] wbn;
    } in_t;

    typedef struct {
        in_t         in;
        logic        stall;
        logic        bubble;
        logic        flush;
        logic        issue;
        logic [15:0] busy;
    } vec_t;

    typedef struct {
        int r;
        int due;
    } wr_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic in_t vin(input logic v, input logic [3:0] rs, input logic rsu,
                                input logic [3:0] rt, input logic rtu, input logic wr,
                                input logic [3:0] wn, input logic ctl, input logic res,
                                input logic mis, input logic wbw, input logic [3:0] wbn);
        in_t x;
        x.v = v; x.rs = rs; x.rsu = rsu; x.rt = rt; x.rtu = rtu; x.wr = wr;
        x.wn = wn; x.ctl = ctl; x.res = res; x.mis = mis; x.wbw = wbw; x.wbn = wbn;
        return x;
    endfunction

    function automatic vec_t vx(input in_t x, input logic s, input logic b, input logic f,
                                input logic i, input logic [15:0] busy);
        vec_t t;
        t.in = x; t.stall = s; t.bubble = b; t.flush = f; t.issue = i; t.busy = busy;
        return t;
    endfunction

    task automatic drive(input in_t x);
        bus.id_valid   = x.v;
        bus.id_rs      = x.rs;
        bus.id_rs_used = x.rsu;
        bus.id_rt      = x.rt;
        bus.id_rt_used = x.rtu;
        bus.id_wr_reg  = x.wr;
        bus.id_wregno  = x.wn;
        bus.id_is_ctl  = x.ctl;
        bus.ex_resolve = x.res;
        bus.ex_mispred = x.mis;
        bus.wb_wr_reg  = x.wbw;
        bus.wb_wregno  = x.wbn;
    endtask

    // Advance to just after the next active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic s, input logic b, input logic f,
                              input logic i, input logic [15:0] busy);
        check({tag, ".stall_pipe"}, 32'(bus.stall_pipe), 32'(s));
        check({tag, ".bubble_id"},  32'(bus.bubble_id),  32'(b));
        check({tag, ".flush"},      32'(bus.flush),      32'(f));
        check({tag, ".issue"},      32'(bus.issue),      32'(i));
        check({tag, ".pend_busy"},  32'(bus.pend_busy),  32'(busy));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[17];
        in_t  idle;
        int   raw_exp;
        int   got;
        wr_t  inflight[$];
        int   cnt[16];
        bit   waiting, flushing;
        int   cyc;

        idle = vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Sequence applied cycle by cycle straight out of reset.
        vecs[0]  = vx(idle,                                      0, 0, 0, 0, 16'h0000);
        vecs[1]  = vx(vin(1, 1, 1, 2, 1, 1, 3, 0, 0, 0, 0, 0),   0, 0, 0, 1, 16'h0000);
        vecs[2]  = vx(vin(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0),   1, 1, 0, 0, 16'h0008);
        vecs[3]  = vx(vin(1, 3, 0, 5, 1, 1, 7, 0, 0, 0, 0, 0),   0, 0, 0, 1, 16'h0008);
        vecs[4]  = vx(vin(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0),   1, 1, 0, 0, 16'h0088);
        vecs[5]  = vx(vin(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 3),   0, 0, 0, 1, 16'h0088);
        vecs[6]  = vx(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7),   0, 0, 0, 0, 16'h0080);
        vecs[7]  = vx(vin(1, 0, 0, 0, 0, 1, 15, 1, 0, 0, 0, 0),  0, 0, 0, 1, 16'h0000);
        vecs[8]  = vx(vin(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),   1, 1, 0, 0, 16'h8000);
        vecs[9]  = vx(vin(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0),   1, 1, 0, 0, 16'h8000);
        vecs[10] = vx(vin(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0),   0, 1, 1, 0, 16'h8000);
        vecs[11] = vx(vin(1, 15, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0),  1, 1, 0, 0, 16'h8000);
        vecs[12] = vx(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 15),  0, 0, 0, 0, 16'h8000);
        vecs[13] = vx(vin(1, 15, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0),  0, 0, 0, 1, 16'h0000);
        vecs[14] = vx(vin(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0),   1, 1, 0, 0, 16'h0000);
        vecs[15] = vx(vin(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0),   0, 0, 0, 1, 16'h0000);
        vecs[16] = vx(idle,                                      0, 0, 0, 0, 16'h0000);

        // Outputs held at zero while reset is asserted, even with a hazard on the inputs.
        reset = 1'b1;
        drive(vin(1, 3, 1, 3, 1, 1, 3, 1, 1, 1, 0, 0));
        @(negedge clk);
        check_outs("reset", 0, 0, 0, 0, 16'h0000);
        do_reset();

        for (int k = 0; k < 17; k++) begin
            drive(vecs[k].in);
            @(negedge clk);
            check_outs($sformatf("vec%0d", k), vecs[k].stall, vecs[k].bubble,
                       vecs[k].flush, vecs[k].issue, vecs[k].busy);
            step();
        end

        // RAW: producer ADD r3 issues, dependent ADD r4,r3,r1 waits for WB of r3.
        do_reset();
        raw_exp = BYP ? 3 : 4;
        drive(vin(1, 1, 1, 2, 1, 1, 3, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("raw.producer_issue", 32'(bus.issue), 32'd1);
        step();
        got = -1;
        for (int k = 1; k <= 8; k++) begin
            drive(vin(1, 3, 1, 1, 1, 1, 4, 0, 0, 0, (k == 3), 3));
            @(negedge clk);
            if (k < raw_exp) check($sformatf("raw.stall_c%0d", k), 32'(bus.stall_pipe), 32'd1);
            if (bus.issue) begin
                got = k;
                step();
                break;
            end
            step();
        end
        check("raw.consumer_issue_cycle", 32'(got), 32'(raw_exp));
        drive(idle);
        @(negedge clk);
        check("raw.busy_after_wb", 32'(bus.pend_busy), 32'h0010);
        step();
        drive(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4));
        step();
        drive(idle);
        @(negedge clk);
        check("raw.busy_clear", 32'(bus.pend_busy), 32'h0000);

        // WAW: three writers to r7 fill the counter; the fourth waits for a WB.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(vin(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0));
            @(negedge clk);
            check($sformatf("waw.writer%0d_issue", k), 32'(bus.issue), 32'd1);
            step();
        end
        drive(vin(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("waw.full_stall", 32'(bus.stall_pipe), 32'd1);
        check("waw.full_no_issue", 32'(bus.issue), 32'd0);
        check("waw.busy", 32'(bus.pend_busy), 32'h0080);
        step();
        drive(vin(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 7));
        step();
        drive(vin(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("waw.released_issue", 32'(bus.issue), 32'd1);
        step();
        for (int k = 0; k < 3; k++) begin
            drive(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7));
            @(negedge clk);
            check($sformatf("waw.drain%0d_busy", k), 32'(bus.pend_busy), 32'h0080);
            step();
        end
        drive(idle);
        @(negedge clk);
        check("waw.drained", 32'(bus.pend_busy), 32'h0000);

        // Simultaneous issue and WB on r2 with one write pending keeps the count at 1.
        do_reset();
        drive(vin(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0));
        step();
        drive(vin(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 2));
        @(negedge clk);
        check("same.issue", 32'(bus.issue), 32'd1);
        step();
        drive(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2));
        @(negedge clk);
        check("same.busy_kept", 32'(bus.pend_busy), 32'h0004);
        step();
        drive(idle);
        @(negedge clk);
        check("same.busy_clear", 32'(bus.pend_busy), 32'h0000);

        // Reset in the middle of CTL_WAIT.
        do_reset();
        drive(vin(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0));
        step();
        drive(vin(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("rst_wait.stall", 32'(bus.stall_pipe), 32'd1);
        reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_outs($sformatf("rst_wait.held%0d", k), 0, 0, 0, 0, 16'h0000);
            step();
        end
        reset = 1'b0;
        @(negedge clk);
        check_outs("rst_wait.after", 0, 0, 0, 1, 16'h0000);
        step();

        // Randomized run: WB arrives three cycles after issue; expectations
        // come from counting in-flight writes per register.
        do_reset();
        waiting  = 1'b0;
        flushing = 1'b0;
        for (cyc = 0; cyc < 3000; cyc++) begin
            in_t x;
            bit  hz, raw, waw, e_stall, e_bubble, e_flush, e_issue;
            logic [15:0] e_busy;
            x.v   = ($urandom_range(0, 9) < 8);
            x.rs  = 4'($urandom_range(0, 5));
            x.rt  = 4'($urandom_range(0, 5));
            x.rsu = 1'($urandom_range(0, 1));
            x.rtu = 1'($urandom_range(0, 1));
            x.wr  = ($urandom_range(0, 3) != 0);
            x.wn  = 4'($urandom_range(0, 5));
            x.ctl = ($urandom_range(0, 6) == 0);
            x.res = waiting ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
            x.mis = 1'($urandom_range(0, 1));
            x.wbw = (inflight.size() > 0) && (inflight[0].due == cyc);
            x.wbn = x.wbw ? 4'(inflight[0].r) : 4'($urandom_range(0, 15));
            drive(x);
            @(negedge clk);

            foreach (cnt[r]) cnt[r] = 0;
            foreach (inflight[q]) cnt[inflight[q].r]++;
            raw = x.v && ((x.rsu && cnt[x.rs] != 0 &&
                           !(BYP && cnt[x.rs] == 1 && x.wbw && x.wbn == x.rs)) ||
                          (x.rtu && cnt[x.rt] != 0 &&
                           !(BYP && cnt[x.rt] == 1 && x.wbw && x.wbn == x.rt)));
            waw = x.v && x.wr && (cnt[x.wn] == 3);
            hz  = raw || waw;
            e_flush  = flushing;
            e_stall  = waiting || (!flushing && hz);
            e_bubble = e_stall || flushing;
            e_issue  = !waiting && !flushing && x.v && !hz;
            for (int r = 0; r < 16; r++) e_busy[r] = (cnt[r] != 0);
            check_outs($sformatf("rand%0d", cyc), e_stall, e_bubble, e_flush, e_issue, e_busy);

            if (x.wbw) void'(inflight.pop_front());
            if (e_issue && x.wr) inflight.push_back('{r: int'(x.wn), due: cyc + 3});
            if (waiting) begin
                if (x.res) begin
                    waiting  = 1'b0;
                    flushing = x.mis;
                end
            end else if (flushing) begin
                flushing = 1'b0;
            end else if (e_issue && x.ctl) begin
                waiting = 1'b1;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
